// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared data-memory access type encodings and size decode helpers
package lsu_pkg;

  localparam logic [2:0] DM_WORD       = 3'b000;
  localparam logic [2:0] DM_HALFWORD   = 3'b001;
  localparam logic [2:0] DM_HALFWORD_U = 3'b010;
  localparam logic [2:0] DM_BYTE       = 3'b011;
  localparam logic [2:0] DM_BYTE_U     = 3'b100;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

  // Unrecognised encodings fall through to a full word access.
  function automatic size_e dm_size(input logic [2:0] t);
    case (t)
      DM_BYTE, DM_BYTE_U:         return SZ_BYTE;
      DM_HALFWORD, DM_HALFWORD_U: return SZ_HALF;
      default:                    return SZ_WORD;
    endcase
  endfunction

  function automatic logic dm_signed(input logic [2:0] t);
    return (t == DM_BYTE) || (t == DM_HALFWORD);
  endfunction

endpackage

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - data-memory request/acknowledge bus between the LSU and memory
interface lsu_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane enables, store replication and load extract/extend
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  dm_type_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] bus_rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  size_e       sz;
  logic        sgn;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    sz     = dm_size(dm_type_i);
    sgn    = dm_signed(dm_type_i);
    lane_h = offset_i[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
    case (offset_i)
      2'd0:    lane_b = bus_rdata_i[7:0];
      2'd1:    lane_b = bus_rdata_i[15:8];
      2'd2:    lane_b = bus_rdata_i[23:16];
      default: lane_b = bus_rdata_i[31:24];
    endcase

    be_o       = 4'b1111;
    wdata_o    = wdata_i;
    rdata_o    = bus_rdata_i;
    misalign_o = (offset_i != 2'd0);
    case (sz)
      SZ_BYTE: begin
        be_o       = 4'b0001 << offset_i;
        wdata_o    = {4{wdata_i[7:0]}};
        rdata_o    = {{24{sgn & lane_b[7]}}, lane_b};
        misalign_o = 1'b0;
      end
      SZ_HALF: begin
        be_o       = 4'b0011 << {offset_i[1], 1'b0};
        wdata_o    = {2{wdata_i[15:0]}};
        rdata_o    = {{16{sgn & lane_h[15]}}, lane_h};
        misalign_o = offset_i[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - single-outstanding load/store unit: IDLE -> REQ -> DONE with bus timeout
module lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        start_i,
  input  logic        mem_we_i,
  input  logic [2:0]  dm_type_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o,
  output logic        timeout_o,
  lsu_if.master       bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    dm_type_q;
  logic [1:0]    off_q;
  logic          done_q, misalign_q, timeout_q;
  logic [31:0]   rdata_q;
  logic          bus_req_q, bus_we_q;
  logic [31:0]   bus_addr_q, bus_wdata_q;
  logic [3:0]    bus_be_q;

  logic [2:0]    al_type;
  logic [1:0]    al_off;
  logic [3:0]    al_be;
  logic [31:0]   al_wdata, al_rdata;
  logic          al_misalign;

  // Lane logic sees the live request in IDLE and the latched one while waiting on the bus.
  assign al_type = (state_q == S_IDLE) ? dm_type_i   : dm_type_q;
  assign al_off  = (state_q == S_IDLE) ? addr_i[1:0] : off_q;

  lsu_align u_align (
    .dm_type_i   (al_type),
    .offset_i    (al_off),
    .wdata_i     (wdata_i),
    .bus_rdata_i (bus.bus_rdata),
    .be_o        (al_be),
    .wdata_o     (al_wdata),
    .rdata_o     (al_rdata),
    .misalign_o  (al_misalign)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dm_type_q   <= DM_WORD;
      off_q       <= 2'd0;
      done_q      <= 1'b0;
      misalign_q  <= 1'b0;
      timeout_q   <= 1'b0;
      rdata_q     <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            dm_type_q  <= dm_type_i;
            off_q      <= addr_i[1:0];
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
            rdata_q    <= '0;
            misalign_q <= al_misalign;
            if (al_misalign) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q     <= S_REQ;
              bus_req_q   <= 1'b1;
              bus_we_q    <= mem_we_i;
              bus_addr_q  <= {addr_i[31:2], 2'b00};
              bus_be_q    <= al_be;
              bus_wdata_q <= al_wdata;
            end
          end
        end
        S_REQ: begin
          if (bus.bus_ack || cnt_q == CW'(TIMEOUT - 1)) begin
            state_q     <= S_DONE;
            done_q      <= 1'b1;
            timeout_q   <= !bus.bus_ack;
            rdata_q     <= (bus.bus_ack && !bus_we_q) ? al_rdata : 32'd0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o     = rstn_i & (((state_q == S_IDLE) & start_i) | (state_q == S_REQ));
  assign done_o     = done_q;
  assign rdata_o    = rdata_q;
  assign misalign_o = misalign_q;
  assign timeout_o  = timeout_q;

  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_be    = bus_be_q;
  assign bus.bus_wdata = bus_wdata_q;

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL set the maximum number of cycles bus_req is held without bus_ack before the access aborts.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rstn  in  1  reset SHALL be asynchronous and active-low.
REQ-004 start  in  1  one-cycle request from execute stage to perform an access.
REQ-005 mem_we  in  1  1 = store, 0 = load; sampled with start.
REQ-006 dm_type  in  3  access size/sign; sampled with start.
REQ-007 addr  in  32  byte address (ALU result); sampled with start.
REQ-008 wdata  in  32  store data (rs2), bits [7:0]/[15:0]/[31:0] used per size; sampled with start.
REQ-009 busy  out  1  stall to PC/pipeline.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 rdata  out  32  extended load result, valid when done=1.
REQ-012 misalign  out  1  valid with done; access was misaligned.
REQ-013 timeout  out  1  valid with done; bus never acknowledged.
REQ-014 bus_req, bus_we  out  1 each  data-memory request and write strobe.
REQ-015 bus_addr  out  32  word address, bits [1:0] SHALL be 0.
REQ-016 bus_be  out  4  byte-lane enables.
REQ-017 bus_wdata  out  32  lane-replicated store data.
REQ-018 bus_ack  in  1; bus_rdata  in  32  memory acknowledge and read word.

Function
REQ-019 FSM states IDLE, REQ, DONE; start in IDLE SHALL latch addr/wdata/mem_we/dm_type and go to REQ (aligned) or DONE with misalign=1 (misaligned).
REQ-020 Misaligned: word with addr[1:0]!=0, halfword with addr[0]!=0; bus_req SHALL never assert for it.
REQ-021 In REQ, bus_req=1 and bus_we/bus_addr/bus_be/bus_wdata SHALL stay stable until bus_ack is sampled 1.
REQ-022 bus_ack in REQ SHALL capture bus_rdata, drop bus_req next cycle and move to DONE; minimum start-to-done latency SHALL be 2 cycles.
REQ-023 A REQ cycle counter SHALL abort after TIMEOUT cycles without ack: bus_req drops, DONE entered with timeout=1.
REQ-024 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-025 busy SHALL be 1 combinationally in an IDLE start cycle and in REQ, and 0 in DONE and idle IDLE.
REQ-026 start while not IDLE SHALL be ignored; bus_ack outside REQ SHALL be ignored.
REQ-027 bus_be: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111.
REQ-028 bus_wdata: byte replicated x4, half replicated x2, word as is.
REQ-029 Load: selected lane shifted to bit 0, sign-extended for dm_byte/dm_halfword, zero-extended for unsigned types; stores SHALL return rdata=0.
REQ-030 Undefined dm_type codes SHALL be treated as word.

Reset
REQ-031 rstn low SHALL immediately force IDLE, counter 0, and busy, done, misalign, timeout, bus_req, bus_we, bus_be, bus_addr, bus_wdata, rdata all 0, including mid-access.

Structure
REQ-032 dm_type encodings (dm_word 000, dm_halfword 001, dm_halfword_unsigned 010, dm_byte 011, dm_byte_unsigned 100) SHALL live in shared ctrl_encode_def.v; FSM state codes stay local.
REQ-033 Lane logic (bus_be, bus_wdata, load extract/extend) SHALL be one combinational sub-module lsu_align.

Verification
REQ-034 Load dm_byte addr=0x1003, bus_rdata=0x80FF_FF00 acked first cycle -> bus_addr=0x1000, bus_be=1000, done at cycle 2, rdata=0xFFFF_FF80.
REQ-035 Store dm_halfword addr=0x2002 wdata=0x1234_ABCD, ack after 3 cycles -> bus_be=1100, bus_wdata=0xABCD_ABCD, outputs stable 3 cycles, done at cycle 4.
REQ-036 Load dm_word addr=0x0001 -> no bus_req, done next cycle, misalign=1.
REQ-037 No ack, TIMEOUT=16 -> bus_req high 16 cycles, then done with timeout=1, busy 0.
REQ-038 rstn low mid-REQ -> bus_req and busy 0 same cycle; second start during REQ -> ignored, one done only.
